seq_divider: RTL and testbench

Iterative unsigned restoring divider for the CPU datapath. It produces a quotient and remainder one bit per clock. It uses the same trial-subtraction arithmetic as the ALU subtract path: invert the divisor and set carry-in to 1. It is a multi-cycle functional unit controlled by a start/busy/done handshake from the CPU control FSM.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 29 ++
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared CPU datapath constants: divider FSM state encoding and default data width.
package seq_divider_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   inv_divisor;
  logic [WIDTH+1:0] trial;
  logic             unused_bits;

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit before subtracting.
  always_comb begin
    partial     = {rem_i, quo_msb_i};
    inv_divisor = ~{1'b0, divisor_i};
    trial       = {1'b0, partial} + {1'b0, inv_divisor} + {{(WIDTH + 1){1'b0}}, 1'b1};
    q_bit_o     = trial[WIDTH+1];
    next_rem_o  = q_bit_o ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  end

  // After a successful subtract (or a failed one) the result is below the divisor.
  assign unused_bits = ^{trial[WIDTH], partial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_next;

  seq_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_msb_i (quo_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .next_rem_o(step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    quo_next = {quo_q[WIDTH-2:0], step_qbit};
  end

  // Working registers (rem_q/quo_q) are kept apart from the result registers so the
  // previous result stays visible while a new division runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            dvsr_q <= divisor;
            rem_q  <= '0;
            quo_q  <= dividend;
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
            if (divisor == '0) begin
              quot_q  <= '1;
              remd_q  <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StRun;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            quot_q  <= quo_next;
            remd_q  <= step_rem;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, handshake corner cases, random vs model.
module tb_seq_divider;

  localparam int unsigned W = 16;
  localparam int MaxWait = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference for unsigned division with the divide-by-zero convention.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Called #1 after a posedge. lat = edges after the accepting edge until done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                        output int busy_n, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_n++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(posedge clk);
    #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int           lat;
    int           busy_n;
    int           n;
    int           dones;
    int           first_done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;

    vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,     r: 16'd2,      z: 1'b0};
    vecs[1] = '{a: 16'hFFFF,  b: 16'h0001,   q: 16'hFFFF,   r: 16'h0000,   z: 1'b0};
    vecs[2] = '{a: 16'h0003,  b: 16'h000A,   q: 16'h0000,   r: 16'h0003,   z: 1'b0};
    vecs[3] = '{a: 16'h8000,  b: 16'h8000,   q: 16'h0001,   r: 16'h0000,   z: 1'b0};
    vecs[4] = '{a: 16'd5,     b: 16'd0,      q: 16'hFFFF,   r: 16'd5,      z: 1'b1};
    vecs[5] = '{a: 16'hFFFF,  b: 16'hFFFE,   q: 16'h0001,   r: 16'h0001,   z: 1'b0};
    vecs[6] = '{a: 16'h0000,  b: 16'h0007,   q: 16'h0000,   r: 16'h0000,   z: 1'b0};
    vecs[7] = '{a: 16'hFFFE,  b: 16'hFFFF,   q: 16'h0000,   r: 16'hFFFE,   z: 1'b0};
    vecs[8] = '{a: 16'h1234,  b: 16'h0010,   q: 16'h0123,   r: 16'h0004,   z: 1'b0};
    vecs[9] = '{a: 16'h0000,  b: 16'h0000,   q: 16'hFFFF,   r: 16'h0000,   z: 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, busy_n, q, r, z);
      check($sformatf("vec%0d_quotient", i), {16'd0, q}, {16'd0, vecs[i].q});
      check($sformatf("vec%0d_remainder", i), {16'd0, r}, {16'd0, vecs[i].r});
      check($sformatf("vec%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 0 : W);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].z ? 0 : W);
    end

    // Start while busy is ignored
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    n          = 5;
    dones      = 0;
    first_done = -1;
    q          = '0;
    r          = '0;
    while (n < 30) begin
      if (done) begin
        dones++;
        if (first_done < 0) begin
          first_done = n;
          q = quotient;
          r = remainder;
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_start_quotient", {16'd0, q}, 32'd14);
    check("busy_start_remainder", {16'd0, r}, 32'd2);
    check("busy_start_done_count", dones, 1);
    check("busy_start_latency", first_done, W);

    // Back-to-back start during the done cycle
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_first_latency", lat, W);
    check("b2b_first_quotient", {16'd0, quotient}, 32'd14);
    check("b2b_first_remainder", {16'd0, remainder}, 32'd2);
    dividend = 16'd81;
    divisor  = 16'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy_no_bubble", {31'd0, busy}, 32'd1);
    check("b2b_done_dropped", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < MaxWait) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_second_latency", lat, W);
    check("b2b_second_quotient", {16'd0, quotient}, 32'd9);
    check("b2b_second_remainder", {16'd0, remainder}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b_done_pulse_width", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-run
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_quotient", {16'd0, quotient}, 32'd0);
    check("arst_remainder", {16'd0, remainder}, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    #1;
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("arst_no_done_or_busy", dones, 0);
    run_op(16'd100, 16'd7, lat, busy_n, q, r, z);
    check("arst_rerun_quotient", {16'd0, q}, 32'd14);
    check("arst_rerun_remainder", {16'd0, r}, 32'd2);
    check("arst_rerun_latency", lat, W);

    // Randomized against the reference model
    for (int k = 0; k < 1000; k++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0) b = '0;
      else if (sel < 5) b = W'($urandom_range(1, 15));
      else b = W'($urandom);
      a = (sel == 15) ? W'($urandom_range(0, 20)) : W'($urandom);
      model(a, b, eq, er, ez);
      run_op(a, b, lat, busy_n, q, r, z);
      check($sformatf("rnd%0d_quotient %0h/%0h", k, a, b), {16'd0, q}, {16'd0, eq});
      check($sformatf("rnd%0d_remainder %0h/%0h", k, a, b), {16'd0, r}, {16'd0, er});
      check($sformatf("rnd%0d_dbz", k), {31'd0, z}, {31'd0, ez});
      check($sformatf("rnd%0d_latency", k), lat, ez ? 0 : W);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
